// File: rtl/step_counter_fsm.sv
// step_counter_fsm: responder side of the go/done counter handshake.
// Accepts a go, latches range/step/direction, counts once per div_clk, then pulses done.
// Ports:
//   div_clk, rst (async, active-high)
//   go, abort, dir, start_val, end_val, step (inputs)
//   out, busy, done (registered outputs)
module step_counter_fsm #(
  parameter int WIDTH = 4
) (
  input  logic             div_clk,
  input  logic             rst,
  input  logic             go,
  input  logic             abort,
  input  logic             dir,
  input  logic [WIDTH-1:0] start_val,
  input  logic [WIDTH-1:0] end_val,
  input  logic [WIDTH-1:0] step,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_q;
  logic [WIDTH-1:0] out_q;
  logic             busy_q;
  logic             done_q;
  logic             dir_q;
  logic [WIDTH-1:0] end_q;
  logic [WIDTH-1:0] step_q;

  logic             accept;
  logic [WIDTH-1:0] step_eff;
  logic [WIDTH:0]   sum_w;
  logic [WIDTH:0]   lim_w;
  logic [WIDTH-1:0] up_d;
  logic [WIDTH-1:0] dn_d;
  logic [WIDTH-1:0] cnt_d;

  // go is only honoured in IDLE/DONE and loses to abort.
  assign accept = go && !abort &&
                  ((state_q == IDLE) || (state_q == DONE));

  assign step_eff = (step == '0) ? ONE : step;

  // One extra bit so end+step or out+step never aliases.
  assign sum_w = {1'b0, out_q} + {1'b0, step_q};
  assign lim_w = {1'b0, end_q} + {1'b0, step_q};

  assign up_d = (sum_w >= {1'b0, end_q}) ?
                end_q : sum_w[WIDTH-1:0];
  assign dn_d = ({1'b0, out_q} <= lim_w) ?
                end_q : (out_q - step_q);
  assign cnt_d = dir_q ? up_d : dn_d;

  always_ff @(posedge div_clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dir_q   <= 1'b0;
      end_q   <= '0;
      step_q  <= ONE;
    end else begin
      if (accept) begin
        dir_q   <= dir;
        end_q   <= end_val;
        step_q  <= step_eff;
        out_q   <= start_val;
        state_q <= COUNT;
        busy_q  <= 1'b1;
        done_q  <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
          end
          COUNT: begin
            if (abort) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else if (out_q == end_q) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              out_q <= cnt_d;
            end
          end
          DONE: begin
            state_q <= IDLE;
            done_q  <= 1'b0;
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign out  = out_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
